dispatch_slot_alloc: RTL and testbench
======================================

// Module: dispatch_slot_alloc
// PURPOSE
//  Front-end writer for dispatch_reg_storage. Accepts decoded instructions (rs1/rs2/rW) over a valid/ready
//  handshake and assigns each a free window slot in strict ring order. It then drives the storage insert
//  port, and drives the delete port on in-order retire or on a pipeline flush.
//  It sits between decode and the dispatch register storage and owns slot occupancy.
// PARAMETERS
//  NUM_SLOTS  16  window entries; power of two, >= 2
//  SLOT_W     4   slot index width = log2(NUM_SLOTS)
//  REG_W      5   architectural register index width
// PORTS
//  clock         in   1         system clock, rising edge
//  reset         in   1         asynchronous, active-low reset
//  in_valid      in   1         decode offers an instruction
//  in_ready      out  1         allocator can accept this cycle
//  in_rs1        in   REG_W     source register 1
//  in_rs2        in   REG_W     source register 2
//  in_rW         in   REG_W     destination register
//  ret_valid     in   1         retire the oldest occupied slot
//  flush         in   1         one-cycle pulse; discard all occupied slots
//  reg_insert    out  1         insert strobe to storage
//  reg_rs1       out  REG_W     registered rs1 to storage
//  reg_rs2       out  REG_W     registered rs2 to storage
//  reg_rW        out  REG_W     registered rW to storage
//  reg_indexIns  out  SLOT_W    slot being written
//  reg_delete    out  1         delete strobe to storage
//  reg_indexDel  out  SLOT_W    slot being deleted
//  count         out  SLOT_W+1  occupied slots, 0..NUM_SLOTS
//  busy          out  1         high while in DRAIN state
// BEHAVIOUR
//  - State: tail (next alloc slot), head (oldest slot), count, and a 2-state FSM {RUN, DRAIN}.
//  - Reset (reset==0, async): RUN; head=tail=0; count=0; all reg_* outputs=0; busy=0.
//    in_ready is 0 while reset is asserted.
//  - in_ready = (state==RUN) && (count!=NUM_SLOTS) && !flush. It is driven from registered state only;
//    a same-cycle retire does not free a slot for a same-cycle accept.
//  - Accept = in_valid && in_ready. On the next edge: reg_insert=1, reg_rs1/rs2/rW=inputs,
//    reg_indexIns=tail, tail+=1 (wraps NUM_SLOTS-1 -> 0). Latency is 1 cycle.
//    With no accept, reg_insert=0 and the data/index outputs hold their values.
//  - Retire = ret_valid && state==RUN && count!=0 && !flush. On the next edge: reg_delete=1,
//    reg_indexDel=head, head+=1 (wraps). ret_valid with count==0 is ignored; there is no error.
//  - Accept and retire in the same cycle: both strobes fire on the next edge and count is unchanged.
//    Accept only: count+1. Retire only: count-1.
//  - flush has priority over accept and retire in the same cycle.
//    If count==0, flush is a no-op and the FSM stays in RUN.
//    Otherwise the FSM goes to DRAIN and busy=1.
//  - DRAIN: each cycle deletes one slot at head (reg_delete=1, reg_indexDel=head, head+=1, count-=1).
//    ret_valid, in_valid and further flush pulses are ignored. When count reaches 0 the FSM returns to RUN
//    with head==tail; busy falls on that same edge.
//  - A full drain takes count cycles. reg_insert and reg_delete are never both asserted for the same index.
//  - A reset mid-DRAIN or mid-operation returns everything to reset values immediately.
// CONFIGURATION
//  DISPATCH_ALLOC_STATS_EN
//  - Defined: adds output stall_cnt [31:0]. It increments each cycle that in_valid && !in_ready &&
//    state==RUN, saturates at 32'hFFFF_FFFF, and resets to 0.
//  - Undefined: the port and counter are absent and behaviour is otherwise identical.
// TESTING
//  1. After reset release, in_valid=1 with rs1=5'b01010, rs2=5'b10101, rW=5'b11100
//     -> the next cycle shows reg_insert=1, indexIns=0 and those fields; count=1.
//  2. 16 back-to-back accepts -> indexIns 0..15, count=16, in_ready=0.
//     The 17th offer stalls and count holds at 16.
//  3. Full window, then ret_valid with in_valid in the same cycle -> reg_delete idx 0 and no insert.
//     Next cycle in_ready=1; the accept lands at idx 0 (wrap).
//  4. count=3 (head=5), flush pulse -> busy=1; reg_delete on idx 5, 6, 7 in consecutive cycles;
//     then count=0, busy=0 and in_ready=1.
//  5. Retire on empty, and flush on empty -> no strobes, state stays RUN, count=0.
//  6. Reset asserted during DRAIN -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/dispatch_slot_alloc_if.sv
// ============================================================================
// Module      : dispatch_slot_alloc_if
// Description : Bundle of the decode-side handshake, retire/flush controls and
//               the dispatch register storage write/delete port used by
//               dispatch_slot_alloc.
//               master : decode / retire / storage side (drives in_*, ret_valid,
//                        flush; observes everything the allocator produces)
//               slave  : the allocator itself
//               Optional stall_cnt exists only when DISPATCH_ALLOC_STATS_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dispatch_slot_alloc_if #(
  parameter int SLOT_W = 4,
  parameter int REG_W  = 5
);
  // decode handshake
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [REG_W-1:0]  in_rW;
  // retire / flush
  logic              ret_valid;
  logic              flush;
  // storage port
  logic              reg_insert;
  logic [REG_W-1:0]  reg_rs1;
  logic [REG_W-1:0]  reg_rs2;
  logic [REG_W-1:0]  reg_rW;
  logic [SLOT_W-1:0] reg_indexIns;
  logic              reg_delete;
  logic [SLOT_W-1:0] reg_indexDel;
  // status
  logic [SLOT_W:0]   count;
  logic              busy;
`ifdef DISPATCH_ALLOC_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  modport master (
    output in_valid, in_rs1, in_rs2, in_rW, ret_valid, flush,
    input  in_ready, reg_insert, reg_rs1, reg_rs2, reg_rW, reg_indexIns,
    input  reg_delete, reg_indexDel, count, busy
`ifdef DISPATCH_ALLOC_STATS_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rW, ret_valid, flush,
    output in_ready, reg_insert, reg_rs1, reg_rs2, reg_rW, reg_indexIns,
    output reg_delete, reg_indexDel, count, busy
`ifdef DISPATCH_ALLOC_STATS_EN
    , output stall_cnt
`endif
  );

endinterface : dispatch_slot_alloc_if

`default_nettype wire

// File: rtl/dispatch_slot_alloc.sv
// ============================================================================
// Module      : dispatch_slot_alloc
// Description : Front-end writer for dispatch_reg_storage. Accepts decoded
//               instructions over valid/ready, assigns window slots in strict
//               ring order, drives the storage insert port, and drives the
//               delete port on in-order retire or while draining after a flush.
// Ports       : clock        - system clock, rising edge
//               reset        - asynchronous, active-low reset
//               bus (slave)  - in_valid/in_ready/in_rs1/in_rs2/in_rW,
//                              ret_valid, flush, reg_insert/reg_rs1/reg_rs2/
//                              reg_rW/reg_indexIns, reg_delete/reg_indexDel,
//                              count, busy [, stall_cnt]
// Config      : DISPATCH_ALLOC_STATS_EN - adds a saturating 32-bit stall_cnt
//               counting RUN-state cycles where decode offers but is refused.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_slot_alloc #(
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_W    = 4,
  parameter int REG_W     = 5
) (
  input  wire logic          clock,
  input  wire logic          reset,
  dispatch_slot_alloc_if.slave bus
);

  localparam logic [0:0]    c_ST_RUN   = 1'b0;
  localparam logic [0:0]    c_ST_DRAIN = 1'b1;
  localparam logic [SLOT_W:0] c_FULL   = (SLOT_W+1)'(NUM_SLOTS);
  localparam logic [SLOT_W:0] c_ONE    = (SLOT_W+1)'(1);

  logic [0:0]        r_state;
  logic [SLOT_W-1:0] r_head;
  logic [SLOT_W-1:0] r_tail;
  logic [SLOT_W:0]   r_count;
  logic              r_insert;
  logic [REG_W-1:0]  r_rs1;
  logic [REG_W-1:0]  r_rs2;
  logic [REG_W-1:0]  r_rW;
  logic [SLOT_W-1:0] r_index_ins;
  logic              r_delete;
  logic [SLOT_W-1:0] r_index_del;

  logic w_run;
  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_accept;
  logic w_retire;
  logic w_flush_go;
  logic w_drain_del;
  logic w_delete;

  always_comb begin
    w_run       = (r_state == c_ST_RUN);
    w_empty     = (r_count == '0);
    w_full      = (r_count == c_FULL);
    // Reset is folded in so in_ready is low the moment reset asserts,
    // independent of the register clear. Only registered occupancy is used:
    // a retire in this cycle cannot make room for an accept in this cycle.
    w_ready     = reset && w_run && !w_full && !bus.flush;
    w_accept    = bus.in_valid && w_ready;
    // flush outranks retire; a flush on an empty window does nothing.
    w_retire    = bus.ret_valid && w_run && !w_empty && !bus.flush;
    w_flush_go  = bus.flush && w_run && !w_empty;
    // DRAIN is only ever entered with count != 0 and left when it hits 0,
    // so every DRAIN cycle has a slot to delete.
    w_drain_del = !w_run;
    w_delete    = w_retire || w_drain_del;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_RUN;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_insert    <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rW        <= '0;
      r_index_ins <= '0;
      r_delete    <= 1'b0;
      r_index_del <= '0;
    end else begin
      r_insert <= w_accept;
      if (w_accept) begin
        r_rs1       <= bus.in_rs1;
        r_rs2       <= bus.in_rs2;
        r_rW        <= bus.in_rW;
        r_index_ins <= r_tail;
        r_tail      <= r_tail + SLOT_W'(1);
      end

      r_delete <= w_delete;
      if (w_delete) begin
        r_index_del <= r_head;
        r_head      <= r_head + SLOT_W'(1);
      end

      case ({w_accept, w_delete})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase

      if (w_flush_go) begin
        r_state <= c_ST_DRAIN;
      end else if (w_drain_del && (r_count == c_ONE)) begin
        // last slot leaves on this edge; head has caught up with tail
        r_state <= c_ST_RUN;
      end
    end
  end

`ifdef DISPATCH_ALLOC_STATS_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  always_comb begin
    w_stall = bus.in_valid && !w_ready && w_run;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

  assign bus.in_ready     = w_ready;
  assign bus.reg_insert   = r_insert;
  assign bus.reg_rs1      = r_rs1;
  assign bus.reg_rs2      = r_rs2;
  assign bus.reg_rW       = r_rW;
  assign bus.reg_indexIns = r_index_ins;
  assign bus.reg_delete   = r_delete;
  assign bus.reg_indexDel = r_index_del;
  assign bus.count        = r_count;
  assign bus.busy         = (r_state == c_ST_DRAIN);

endmodule : dispatch_slot_alloc

`default_nettype wire

// File: tb/tb_dispatch_slot_alloc.sv
// ============================================================================
// Module      : tb_dispatch_slot_alloc
// Description : Self-checking bench for dispatch_slot_alloc. A reference model
//               of head/tail/count/state predicts every insert and delete;
//               predictions are queued when stimulus is applied and popped
//               when the storage strobes appear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dispatch_slot_alloc;

  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = 4;
  localparam int REG_W     = 5;

  typedef struct packed {
    logic [SLOT_W-1:0] idx;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rw;
  } ins_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  dispatch_slot_alloc_if #(.SLOT_W(SLOT_W), .REG_W(REG_W)) bus ();

  dispatch_slot_alloc #(
    .NUM_SLOTS(NUM_SLOTS),
    .SLOT_W   (SLOT_W),
    .REG_W    (REG_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  ins_t              exp_ins[$];
  logic [SLOT_W-1:0] exp_del[$];

  int          m_head  = 0;
  int          m_tail  = 0;
  int          m_count = 0;
  bit          m_drain = 1'b0;
  int unsigned m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every storage strobe must match the oldest prediction.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.reg_insert) begin
        if (exp_ins.size() == 0) begin
          check("ins_spurious", 32'd1, 32'd0);
        end else begin
          ins_t e;
          e = exp_ins.pop_front();
          check("ins_idx", 32'(bus.reg_indexIns), 32'(e.idx));
          check("ins_rs1", 32'(bus.reg_rs1), 32'(e.rs1));
          check("ins_rs2", 32'(bus.reg_rs2), 32'(e.rs2));
          check("ins_rW",  32'(bus.reg_rW),  32'(e.rw));
        end
      end
      if (bus.reg_delete) begin
        if (exp_del.size() == 0) begin
          check("del_spurious", 32'd1, 32'd0);
        end else begin
          logic [SLOT_W-1:0] d;
          d = exp_del.pop_front();
          check("del_idx", 32'(bus.reg_indexDel), 32'(d));
        end
      end
    end
  end

  // Called at posedge+1; applies one cycle of stimulus and returns at the
  // following posedge+1 after checking count/busy.
  task automatic drive(input bit iv, input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                       input logic [REG_W-1:0] w, input bit rv, input bit fl);
    bit ready, acc, del, go;
    bus.in_valid  = iv;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rW     = w;
    bus.ret_valid = rv;
    bus.flush     = fl;
    #1;
    ready = !m_drain && (m_count != NUM_SLOTS) && !fl;
    check("in_ready", 32'(bus.in_ready), 32'(ready));
    acc = iv && ready;
    del = m_drain || (rv && !m_drain && (m_count != 0) && !fl);
    go  = fl && !m_drain && (m_count != 0);
    if (iv && !ready && !m_drain) m_stall++;
    if (acc) begin
      exp_ins.push_back('{idx: SLOT_W'(m_tail), rs1: a, rs2: b, rw: w});
      m_tail = (m_tail + 1) % NUM_SLOTS;
      m_count++;
    end
    if (del) begin
      exp_del.push_back(SLOT_W'(m_head));
      m_head = (m_head + 1) % NUM_SLOTS;
      m_count--;
    end
    if (go) m_drain = 1'b1;
    else if (m_drain && m_count == 0) m_drain = 1'b0;
    @(posedge clock);
    #1;
    check("count", 32'(bus.count), 32'(m_count));
    check("busy",  32'(bus.busy),  32'(m_drain));
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string phase);
    check({phase, "_in_ready"}, 32'(bus.in_ready),     32'd0);
    check({phase, "_count"},    32'(bus.count),        32'd0);
    check({phase, "_busy"},     32'(bus.busy),         32'd0);
    check({phase, "_insert"},   32'(bus.reg_insert),   32'd0);
    check({phase, "_delete"},   32'(bus.reg_delete),   32'd0);
    check({phase, "_idx_ins"},  32'(bus.reg_indexIns), 32'd0);
    check({phase, "_idx_del"},  32'(bus.reg_indexDel), 32'd0);
    check({phase, "_rs1"},      32'(bus.reg_rs1),      32'd0);
    check({phase, "_rs2"},      32'(bus.reg_rs2),      32'd0);
    check({phase, "_rW"},       32'(bus.reg_rW),       32'd0);
  endtask

  task automatic model_reset();
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
    m_drain = 1'b0;
    m_stall = 0;
    exp_ins.delete();
    exp_del.delete();
  endtask

  // Hold reset across two edges, release away from an edge, return at posedge+1.
  task automatic release_reset();
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rW     = '0;
    bus.ret_valid = 1'b0;
    bus.flush     = 1'b0;

    // reset values
    #2;
    check_reset_values("rst");
    release_reset();

    // 1: first accept lands in slot 0 one cycle later
    drive(1'b1, 5'b01010, 5'b10101, 5'b11100, 1'b0, 1'b0);

    // 2: fill the window, then a 17th offer stalls
    for (int i = 1; i < NUM_SLOTS; i++)
      drive(1'b1, REG_W'($urandom), REG_W'($urandom), REG_W'($urandom), 1'b0, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    check("full_count", 32'(bus.count), 32'd16);

    // 3: retire while full frees nothing this cycle; next accept wraps to slot 0
    drive(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
    drive(1'b1, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0);

    // full-window flush; inputs, retires and re-flushes are ignored while draining
    drive(1'b1, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1);
    for (int i = 0; i < NUM_SLOTS; i++)
      drive(1'b1, REG_W'($urandom), REG_W'($urandom), REG_W'($urandom), 1'b1, 1'(i % 2));
    idle();

    // 5: retire and flush on an empty window
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle();

    // 4: build count=3 with head=5, then flush (priority over accept/retire)
    for (int i = 0; i < 7; i++)
      drive(1'b1, REG_W'(i), REG_W'(i + 8), REG_W'(i + 16), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("t4_count", 32'(bus.count), 32'd3);
    drive(1'b1, 5'd30, 5'd30, 5'd30, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1);
    idle();

    // mixed traffic: simultaneous accept/retire, occasional flush
    for (int i = 0; i < 80; i++)
      drive(1'($urandom_range(0, 1)), REG_W'($urandom), REG_W'($urandom), REG_W'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < NUM_SLOTS + 1 && m_drain; i++) idle();

`ifdef DISPATCH_ALLOC_STATS_EN
    check("stall_cnt", bus.stall_cnt, m_stall);
`endif

    // 6: asynchronous reset in the middle of a drain
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'd21, 5'd22, 5'd23, 1'b0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #5;
    check("pre_rst_ins_q", 32'(exp_ins.size()), 32'd0);
    check("pre_rst_del_q", 32'(exp_del.size()), 32'd0);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    release_reset();

    // after reset the ring restarts at slot 0
    drive(1'b1, 5'd17, 5'd18, 5'd19, 1'b0, 1'b0);
    idle();
    #10;
    check("ins_q_empty", 32'(exp_ins.size()), 32'd0);
    check("del_q_empty", 32'(exp_del.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dispatch_slot_alloc

`default_nettype wire
